// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode encoding and helpers for the universal shift register
package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [2:0] {
    USR_HOLD  = 3'd0,
    USR_SHL   = 3'd1,
    USR_SHR   = 3'd2,
    USR_ROL   = 3'd3,
    USR_ROR   = 3'd4,
    USR_LOAD  = 3'd5,
    USR_CLEAR = 3'd6
  } usr_mode_t;

  // Shifts and rotates in either direction all advance the frame counter.
  function automatic logic is_shift_op(input logic [USR_MODE_W-1:0] mode);
    return (mode == USR_SHL) || (mode == USR_SHR) ||
           (mode == USR_ROL) || (mode == USR_ROR);
  endfunction

  function automatic logic is_restart_op(input logic [USR_MODE_W-1:0] mode);
    return (mode == USR_LOAD) || (mode == USR_CLEAR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control/data bundle for univ_shift_reg (par only with USR_PARITY_EN)
interface univ_shift_reg_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
);
  logic                  ce;
  logic [USR_MODE_W-1:0] mode;
  logic                  sin_l;
  logic                  sin_r;
  logic [WIDTH-1:0]      pin;
  logic [WIDTH-1:0]      pout;
  logic                  sout_l;
  logic                  sout_r;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_done;
`ifdef USR_PARITY_EN
  logic                  par;
`endif

  modport master (
`ifdef USR_PARITY_EN
    input  par,
`endif
    output ce, mode, sin_l, sin_r, pin,
    input  pout, sout_l, sout_r, bit_cnt, frame_done
  );

  modport slave (
`ifdef USR_PARITY_EN
    output par,
`endif
    input  ce, mode, sin_l, sin_r, pin,
    output pout, sout_l, sout_r, bit_cnt, frame_done
  );

endinterface

// File: rtl/usr_frame_counter.sv
// rtl/usr_frame_counter.sv - counts shift ops and pulses frame_done every WIDTH of them
module usr_frame_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_op,
  input  logic             restart,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (shift_op) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with frame counting; USR_PARITY_EN adds registered par
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             shift_op;
  logic             restart;

  always_comb begin
    data_d = data_q;
    if (bus.ce) begin
      case (bus.mode)
        USR_SHL:   data_d = {data_q[WIDTH-2:0], bus.sin_l};
        USR_SHR:   data_d = {bus.sin_r, data_q[WIDTH-1:1]};
        USR_ROL:   data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        USR_ROR:   data_d = {data_q[0], data_q[WIDTH-1:1]};
        USR_LOAD:  data_d = bus.pin;
        USR_CLEAR: data_d = '0;
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign shift_op = bus.ce & is_shift_op(bus.mode);
  assign restart  = bus.ce & is_restart_op(bus.mode);

  usr_frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .shift_op   (shift_op),
    .restart    (restart),
    .bit_cnt    (bus.bit_cnt),
    .frame_done (bus.frame_done)
  );

  assign bus.pout   = data_q;
  assign bus.sout_l = data_q[WIDTH-1];
  assign bus.sout_r = data_q[0];

`ifdef USR_PARITY_EN
  // Parity of the next value keeps par aligned with q on the same edge.
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^data_d;
  end
  assign bus.par = par_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed-vector bench with a per-cycle reference model
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  univ_shift_reg_if #(.WIDTH(4)) bus ();

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on a 4-bit value, frame counter as a plain count.
  int m_q = 0;
  int m_cnt = 0;
  int m_fd = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 0; m_cnt = 0; m_fd = 0;
    end else if (!bus.ce) begin
      m_fd = 0;
    end else begin
      m_fd = 0;
      case (int'(bus.mode))
        1, 2, 3, 4: begin
          case (int'(bus.mode))
            1: m_q = (m_q * 2 + int'(bus.sin_l)) % 16;
            2: m_q = m_q / 2 + 8 * int'(bus.sin_r);
            3: m_q = (m_q * 2) % 16 + m_q / 8;
            default: m_q = m_q / 2 + 8 * (m_q % 2);
          endcase
          m_cnt = m_cnt + 1;
          if (m_cnt == 4) begin
            m_cnt = 0;
            m_fd  = 1;
          end
        end
        5: begin m_q = int'(bus.pin); m_cnt = 0; end
        6: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("pout", int'(bus.pout), m_q);
    check("sout_l", int'(bus.sout_l), m_q / 8);
    check("sout_r", int'(bus.sout_r), m_q % 2);
    check("bit_cnt", int'(bus.bit_cnt), m_cnt);
    check("frame_done", int'(bus.frame_done), m_fd);
`ifdef USR_PARITY_EN
    check("par", int'(bus.par), (m_q % 2 + (m_q / 2) % 2 + (m_q / 4) % 2 + m_q / 8) % 2);
`endif
  end

  task automatic step(input int m, input logic c, input logic sl, input logic sr, input logic [3:0] p);
    @(negedge clk);
    bus.mode  = 3'(m);
    bus.ce    = c;
    bus.sin_l = sl;
    bus.sin_r = sr;
    bus.pin   = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.ce = 1'b0; bus.mode = '0; bus.sin_l = 1'b0; bus.sin_r = 1'b0; bus.pin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset pout", int'(bus.pout), 0);
    check("reset bit_cnt", int'(bus.bit_cnt), 0);
    check("reset frame_done", int'(bus.frame_done), 0);

    // Serialise 1,0,1,1 in from the left.
    step(1, 1, 1, 0, 0); check("shl1", int'(bus.pout), 4'b0001);
    step(1, 1, 0, 0, 0); check("shl2", int'(bus.pout), 4'b0010);
    step(1, 1, 1, 0, 0); check("shl3", int'(bus.pout), 4'b0101);
    check("shl3 fd", int'(bus.frame_done), 0);
    step(1, 1, 1, 0, 0); check("shl4", int'(bus.pout), 4'b1011);
    check("shl4 fd", int'(bus.frame_done), 1);
    check("shl4 cnt", int'(bus.bit_cnt), 0);

    // Right shift from 1011: sout_r visible before the edge.
    @(negedge clk);
    bus.mode = 3'(2); bus.ce = 1'b1; bus.sin_r = 1'b0;
    #1 check("sout_r pre", int'(bus.sout_r), 1);
    @(posedge clk); #1;
    check("shr", int'(bus.pout), 4'b0101);
    check("shr fd", int'(bus.frame_done), 0);

    step(5, 1, 0, 0, 4'b1001); check("load", int'(bus.pout), 4'b1001);
    check("load cnt", int'(bus.bit_cnt), 0);
    step(4, 1, 0, 0, 0); check("ror", int'(bus.pout), 4'b1100);
    step(3, 1, 0, 0, 0); check("rol1", int'(bus.pout), 4'b1001);
    step(3, 1, 0, 0, 0); check("rol2", int'(bus.pout), 4'b0011);
    check("rol cnt", int'(bus.bit_cnt), 3);
    check("rol fd", int'(bus.frame_done), 0);

    // Back-to-back frames across a direction change.
    for (int i = 0; i < 9; i++) step((i % 2 == 0) ? 1 : 2, 1, 1'(i), 1'(i + 1), 0);

    // Asynchronous reset mid-frame.
    step(6, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check("pre-rst pout", int'(bus.pout), 4'b0011);
    @(negedge clk);
    bus.mode = 3'(0);
    #1 rst = 1'b1;
    #1 check("async rst pout", int'(bus.pout), 0);
    check("async rst cnt", int'(bus.bit_cnt), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 0);
      check("post-rst fd", int'(bus.frame_done), 0);
    end
    step(1, 1, 1, 0, 0);
    check("post-rst fd4", int'(bus.frame_done), 1);

    // Clock enable low, then reserved mode, then clear.
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 0);
      check("ce0 pout", int'(bus.pout), 4'b1110);
      check("ce0 cnt", int'(bus.bit_cnt), 1);
      check("ce0 fd", int'(bus.frame_done), 0);
    end
    step(7, 1, 1, 1, 4'b1010);
    check("rsvd pout", int'(bus.pout), 4'b1110);
    check("rsvd cnt", int'(bus.bit_cnt), 1);
    step(6, 1, 0, 0, 0); check("clear", int'(bus.pout), 0);

`ifdef USR_PARITY_EN
    step(5, 1, 0, 0, 4'b0111); check("par load", int'(bus.par), 1);
    step(1, 1, 1, 0, 0);
    check("par shl q", int'(bus.pout), 4'b1111);
    check("par shl", int'(bus.par), 0);
`endif

    step(0, 1, 0, 0, 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with frame counting: serial-in/serial-out in either direction, rotate, parallel load and synchronous clear, all selected per cycle by a mode input. It is the general-purpose successor to the fixed 4-bit left-shifting SISO register. It sits between bit-serial links and word-parallel logic as a serialiser, deserialiser or delay line. A built-in shift counter flags each completed WIDTH-bit frame.

## Interface
Parameters:
- WIDTH, default 8: register width in bits; legal values are 2 and above.
- CNT_W, default $clog2(WIDTH): width of the shift counter. Derived; not to be overridden.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- ce, in, 1: clock enable. When low, all state holds and frame_done is 0 on the next cycle.
- mode, in, 3: operation select (encoding under Operation).
- sin_l, in, 1: serial input, enters bit 0 on a left shift.
- sin_r, in, 1: serial input, enters bit WIDTH-1 on a right shift.
- pin, in, WIDTH: parallel load data.
- pout, out, WIDTH: register contents q.
- sout_l, out, 1: q[WIDTH-1], combinational from q.
- sout_r, out, 1: q[0], combinational from q.
- bit_cnt, out, CNT_W: number of shifts or rotates since the last frame boundary, load or clear.
- frame_done, out, 1: registered one-cycle pulse after the WIDTH-th shift or rotate of a frame.
- par, out, 1: even parity of q. Present only with USR_PARITY_EN (see Configuration).

## Operation
Mode encoding; the action applies only when ce=1:
- 0 HOLD: q unchanged.
- 1 SHL: q <= {q[WIDTH-2:0], sin_l}.
- 2 SHR: q <= {sin_r, q[WIDTH-1:1]}.
- 3 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 4 ROR: q <= {q[0], q[WIDTH-1:1]}.
- 5 LOAD: q <= pin.
- 6 CLEAR: q <= 0.
- 7 reserved: behaves exactly as HOLD.

Counter rules:
- SHL, SHR, ROL and ROR are "shift ops".
- A shift op with bit_cnt < WIDTH-1 increments bit_cnt.
- A shift op with bit_cnt == WIDTH-1 wraps bit_cnt to 0 and sets frame_done=1 for the next cycle only.
- LOAD and CLEAR set bit_cnt=0 and frame_done=0. A load therefore always starts a new frame.
- HOLD, reserved and ce=0 leave bit_cnt unchanged and drive frame_done to 0.
- Direction changes within a frame are allowed; every shift op counts regardless of direction.

Reset values: q=0, pout=0, sout_l=0, sout_r=0, bit_cnt=0, frame_done=0, par=0.

## Timing
- Latency: one cycle for every mode. The q update is visible on pout, sout_l and sout_r right after the edge.
- sout_l and sout_r are combinational from q, so a bit entering via sin_l reaches sout_l after exactly WIDTH SHL edges.
- frame_done is high during the cycle after the edge that wrapped bit_cnt. Back-to-back frames pulse it every WIDTH shift cycles with no gap cycle.
- Asserting rst mid-frame clears all state immediately, without waiting for a clock edge. The next frame_done needs a full WIDTH shift ops after rst is released.
- Priority within one edge: rst > ce=0 > mode.

## Configuration
- USR_PARITY_EN defined:
  - par is a registered output equal to the XOR of all bits of q (even parity), updated on the same edge as q.
  - par resets to 0.
- USR_PARITY_EN undefined:
  - The par port is absent.
  - No parity logic is generated.

## Structure
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_mode_t with values USR_HOLD, USR_SHL, USR_SHR, USR_ROL, USR_ROR, USR_LOAD, USR_CLEAR.
  - Constant USR_MODE_W = 3.
- Sub-module usr_frame_counter holds bit_cnt and frame_done:
  - Parameter: WIDTH.
  - Inputs: shift_op and restart.
- The data path stays in univ_shift_reg.

## Test plan
All scenarios use WIDTH=4.
- Reset, then SHL with sin_l = 1,0,1,1 -> q = 0001, 0010, 0101, 1011. frame_done=1 in the cycle after the 4th edge only; bit_cnt=0.
- LOAD pin=1001, then ROR -> 1100, then ROL, ROL -> 1001, 0011. bit_cnt=3 and frame_done stays 0.
- From q=1011, SHR with sin_r=0 -> sout_r=1 before the edge, q=0101 after.
- Two SHL edges, then rst pulsed between edges -> q=0 and bit_cnt=0 immediately. Four further SHL edges are needed for frame_done.
- mode=SHL with ce=0 for 3 cycles, then mode=7 with ce=1 -> q and bit_cnt unchanged, frame_done=0 throughout. Then CLEAR -> q=0000.
- With USR_PARITY_EN: LOAD 0111 -> par=1; SHL with sin_l=1 -> q=1111, par=0.
